// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants for the EX->MEM->WB result path: datapath and register
// address widths, the load flag position inside the memory-op field, and the
// func3 encodings of the load instructions.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;

    // ex_mem_op[3] marks a load; ex_mem_op[2:0] carries func3
    localparam int MEMOP_LOAD = 3;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/result_pipeline_if.sv
// result_pipeline_if
// Instruction bundle presented by the EX stage to the result pipeline.
//   ex_valid    EX presents an instruction (0 = bubble)
//   ex_rd_en    instruction writes rd
//   ex_rd       destination register
//   ex_result   ALU result / link address / load address
//   ex_mem_op   [3]=load, [2:0]=func3
//   ex_addr_lo  byte offset of the load address
// Modports: master = EX stage (drives), slave = result pipeline (receives).
interface result_pipeline_if;
    import riscv_pkg::*;

    logic              ex_valid;
    logic              ex_rd_en;
    logic [REG_AW-1:0] ex_rd;
    logic [XLEN-1:0]   ex_result;
    logic [3:0]        ex_mem_op;
    logic [1:0]        ex_addr_lo;

    modport master (
        output ex_valid, ex_rd_en, ex_rd, ex_result, ex_mem_op, ex_addr_lo
    );

    modport slave (
        input ex_valid, ex_rd_en, ex_rd, ex_result, ex_mem_op, ex_addr_lo
    );

endinterface

// File: rtl/result_pipeline_load_extend.sv
// load_extend
// Combinational load-data aligner/extender placed between M and W.
//   rdata    in   XLEN  word returned by the synchronous data RAM
//   addr_lo  in   2     byte offset of the load address
//   func3    in   3     load type
//   value    out  XLEN  aligned, sign/zero-extended load value
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    // Halfword selection uses addr_lo[1] only; a misaligned halfword simply
    // reads the aligned half that contains it.
    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (func3)
            FUNCT3_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
            FUNCT3_LH:  value = {{(XLEN-16){half_sel[15]}}, half_sel};
            FUNCT3_LHU: value = {{(XLEN-16){1'b0}}, half_sel};
            default:    value = rdata;
        endcase
    end

endmodule

// File: rtl/result_pipeline.sv
// result_pipeline
// EX->MEM->WB result path of the RV32 core. Two registered stages (M, W)
// expose rd/data/load tags for forwarding and load-use detection, finish load
// data on the M->W edge, drive the regfile write port from W and count
// retired instructions.
//   clk, rst_n       clock, asynchronous active-low reset
//   hold             freeze all stages (memory wait)
//   flush            kill the EX instruction being captured this cycle
//   ex               EX instruction bundle (result_pipeline_if.slave)
//   mem_rdata        RAM word, valid while a load sits in M
//   m_rd/m_data/m_load   M-stage forwarding tags
//   w_rd/w_data          W-stage forwarding tags
//   rf_we/rf_waddr/rf_wdata  regfile write port
//   retired          retired-instruction count
module result_pipeline
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               flush,
    result_pipeline_if.slave   ex,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic [REG_AW-1:0]  m_rd,
    output logic [XLEN-1:0]    m_data,
    output logic               m_load,
    output logic [REG_AW-1:0]  w_rd,
    output logic [XLEN-1:0]    w_data,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic [31:0]        retired
);

    // M stage
    logic              m_valid_q;
    logic              m_rd_en_q;
    logic [REG_AW-1:0] m_rd_q;
    logic [XLEN-1:0]   m_result_q;
    logic [3:0]        m_mem_op_q;
    logic [1:0]        m_addr_lo_q;

    // W stage
    logic              w_valid_q;
    logic              w_rd_en_q;
    logic [REG_AW-1:0] w_rd_q;
    logic [XLEN-1:0]   w_data_q;

    logic [31:0]       retired_q;
    logic [XLEN-1:0]   load_value;
    logic [XLEN-1:0]   w_data_d;

    load_extend u_load_extend (
        .rdata   (mem_rdata),
        .addr_lo (m_addr_lo_q),
        .func3   (m_mem_op_q[2:0]),
        .value   (load_value)
    );

    assign w_data_d = m_mem_op_q[MEMOP_LOAD] ? load_value : m_result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            m_rd_en_q   <= 1'b0;
            m_rd_q      <= '0;
            m_result_q  <= '0;
            m_mem_op_q  <= '0;
            m_addr_lo_q <= '0;
            w_valid_q   <= 1'b0;
            w_rd_en_q   <= 1'b0;
            w_rd_q      <= '0;
            w_data_q    <= '0;
            retired_q   <= '0;
        end else if (!hold) begin
            // flush only kills the incoming EX slot; M and W are older than
            // the redirecting branch and always advance.
            m_valid_q   <= ex.ex_valid & ~flush;
            m_rd_en_q   <= ex.ex_rd_en;
            m_rd_q      <= ex.ex_rd;
            m_result_q  <= ex.ex_result;
            m_mem_op_q  <= ex.ex_mem_op;
            m_addr_lo_q <= ex.ex_addr_lo;
            w_valid_q   <= m_valid_q;
            w_rd_en_q   <= m_rd_en_q;
            w_rd_q      <= m_rd_q;
            w_data_q    <= w_data_d;
            if (w_valid_q) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // x0 is never a target, so it never appears as a forwarding tag.
    assign m_rd     = (m_valid_q & m_rd_en_q) ? m_rd_q : '0;
    assign m_data   = m_result_q;
    assign m_load   = m_valid_q & m_mem_op_q[MEMOP_LOAD] & (m_rd != '0);
    assign w_rd     = (w_valid_q & w_rd_en_q) ? w_rd_q : '0;
    assign w_data   = w_data_q;
    assign rf_we    = (w_rd != '0) & ~hold;
    assign rf_waddr = w_rd;
    assign rf_wdata = w_data;
    assign retired  = retired_q;

endmodule
